// File: rtl/register_file_pkg.sv
// Shared constants and types for the 16 x 16-bit register file.
//   DATA_W  : register / data width in bits
//   ADDR_W  : address width (depth = 2**ADDR_W)
//   DEPTH   : number of registers
//   DIS_REG : index of the register mirrored on the front-panel display
package register_file_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int DIS_REG = 15;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/register_file_rf_read_mux.sv
// 16:1 combinational read multiplexer over the packed register array.
// Ports:
//   regs_i : all register contents, entry i at regs_i[i]
//   sel_i  : register index to read
//   data_o : contents of regs_i[sel_i], zero latency
module rf_read_mux
  import register_file_pkg::*;
(
  input  logic [DEPTH-1:0][DATA_W-1:0] regs_i,
  input  addr_t                        sel_i,
  output word_t                        data_o
);

  assign data_o = regs_i[sel_i];

endmodule

// File: rtl/register_file.sv
// 16-entry x 16-bit general-purpose register file.
// Two combinational read ports, one synchronous write port (active-low
// enable), and a dedicated display output that always mirrors R15.
// Ports:
//   CLK    : clock, writes happen on the rising edge
//   RSTBAR : asynchronous active-low reset, clears every register
//   WEBAR  : active-low write enable
//   RA1    : read address, port 1
//   RA2    : read address, port 2
//   WA     : write address
//   WD     : write data
//   RD1    : register[RA1], combinational
//   RD2    : register[RA2], combinational
//   DIS    : register[DIS_REG], combinational
module register_file
  import register_file_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTBAR,
  input  logic              WEBAR,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] DIS
);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][DATA_W-1:0] regs_d;

  // Next-state: only the addressed entry changes, and only when enabled.
  always_comb begin
    regs_d = regs_q;
    if (!WEBAR) begin
      regs_d[WA] = WD;
    end
  end

  // Reset is asynchronous and dominates any pending write.
  always_ff @(posedge CLK or negedge RSTBAR) begin
    if (!RSTBAR) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the registered array: no write bypass, so a
  // read of the address being written shows the old value until the edge.
  rf_read_mux u_mux_rd1 (
    .regs_i (regs_q),
    .sel_i  (RA1),
    .data_o (RD1)
  );

  rf_read_mux u_mux_rd2 (
    .regs_i (regs_q),
    .sel_i  (RA2),
    .data_o (RD2)
  );

  rf_read_mux u_mux_dis (
    .regs_i (regs_q),
    .sel_i  (addr_t'(DIS_REG)),
    .data_o (DIS)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file.
module tb_register_file;

  logic        CLK;
  logic        RSTBAR;
  logic        WEBAR;
  logic [3:0]  RA1;
  logic [3:0]  RA2;
  logic [3:0]  WA;
  logic [15:0] WD;
  logic [15:0] RD1;
  logic [15:0] RD2;
  logic [15:0] DIS;

  int n_checks = 0;
  int n_fail   = 0;

  register_file dut (
    .CLK    (CLK),
    .RSTBAR (RSTBAR),
    .WEBAR  (WEBAR),
    .RA1    (RA1),
    .RA2    (RA2),
    .WA     (WA),
    .WD     (WD),
    .RD1    (RD1),
    .RD2    (RD2),
    .DIS    (DIS)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Stimulus driver: set up a write while the clock is low, take one edge,
  // then release the enable. Outputs settle #1 after the edge.
  task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
    @(negedge CLK);
    WA    = addr;
    WD    = data;
    WEBAR = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    WEBAR = 1'b1;
  endtask

  task automatic test_reset;
    RSTBAR = 1'b0;
    WEBAR  = 1'b1;
    RA1 = 4'd0; RA2 = 4'd7; WA = 4'd0; WD = 16'h0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (RD1 !== 16'h0) begin n_fail++; $display("FAIL reset_rd1 got %h exp %h", RD1, 16'h0); end
    n_checks++;
    if (RD2 !== 16'h0) begin n_fail++; $display("FAIL reset_rd2 got %h exp %h", RD2, 16'h0); end
    n_checks++;
    if (DIS !== 16'h0) begin n_fail++; $display("FAIL reset_dis got %h exp %h", DIS, 16'h0); end
    @(negedge CLK);
    RSTBAR = 1'b1;
  endtask

  task automatic test_reset_clear;
    write_reg(4'd3, 16'hFFFF);
    write_reg(4'd15, 16'hFFFF);
    RA1 = 4'd3;
    #1;
    n_checks++;
    if (RD1 !== 16'hFFFF) begin n_fail++; $display("FAIL clear_pre_rd1 got %h exp %h", RD1, 16'hFFFF); end
    n_checks++;
    if (DIS !== 16'hFFFF) begin n_fail++; $display("FAIL clear_pre_dis got %h exp %h", DIS, 16'hFFFF); end
    // Pulse reset while CLK is low: clearing must not wait for an edge.
    RSTBAR = 1'b0;
    #1;
    n_checks++;
    if (RD1 !== 16'h0) begin n_fail++; $display("FAIL clear_async_rd1 got %h exp %h", RD1, 16'h0); end
    n_checks++;
    if (DIS !== 16'h0) begin n_fail++; $display("FAIL clear_async_dis got %h exp %h", DIS, 16'h0); end
    #1;
    RSTBAR = 1'b1;
  endtask

  task automatic test_basic_write;
    @(negedge CLK);
    WEBAR = 1'b0; WA = 4'd1; WD = 16'd20; RA1 = 4'd1; RA2 = 4'd0;
    #1;
    n_checks++;
    if (RD1 !== 16'd0) begin n_fail++; $display("FAIL basic_before_edge got %0d exp %0d", RD1, 0); end
    @(posedge CLK);
    #1;
    n_checks++;
    if (RD1 !== 16'd20) begin n_fail++; $display("FAIL basic_after_edge got %0d exp %0d", RD1, 20); end
    RA2 = 4'd1;
    #1;
    n_checks++;
    if (RD2 !== 16'd20) begin n_fail++; $display("FAIL basic_rd2 got %0d exp %0d", RD2, 20); end
    @(negedge CLK);
    WEBAR = 1'b1;
  endtask

  task automatic test_held_enable;
    @(negedge CLK);
    WEBAR = 1'b0; WA = 4'd8; WD = 16'd31884;
    @(posedge CLK);
    @(negedge CLK);
    WA = 4'd15; WD = 16'd2222;
    #1;
    n_checks++;
    if (DIS !== 16'd0) begin n_fail++; $display("FAIL held_dis_before got %0d exp %0d", DIS, 0); end
    @(posedge CLK);
    #1;
    n_checks++;
    if (DIS !== 16'd2222) begin n_fail++; $display("FAIL held_dis_after got %0d exp %0d", DIS, 2222); end
    @(negedge CLK);
    WA = 4'd14; WD = 16'd10943;
    @(posedge CLK);
    @(negedge CLK);
    WEBAR = 1'b1;
    RA1 = 4'd8; RA2 = 4'd14;
    #1;
    n_checks++;
    if (RD1 !== 16'd31884) begin n_fail++; $display("FAIL held_r8 got %0d exp %0d", RD1, 31884); end
    n_checks++;
    if (RD2 !== 16'd10943) begin n_fail++; $display("FAIL held_r14 got %0d exp %0d", RD2, 10943); end
    n_checks++;
    if (DIS !== 16'd2222) begin n_fail++; $display("FAIL held_dis got %0d exp %0d", DIS, 2222); end
  endtask

  task automatic test_write_disable;
    @(negedge CLK);
    WEBAR = 1'b1; WA = 4'd8; WD = 16'h1234; RA1 = 4'd8;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      n_checks++;
      if (RD1 !== 16'd31884) begin n_fail++; $display("FAIL disable_r8 edge %0d got %0d exp %0d", k, RD1, 31884); end
    end
  endtask

  task automatic test_alias_same;
    @(negedge CLK);
    RA1 = 4'd14; RA2 = 4'd14;
    #1;
    n_checks++;
    if (RD1 !== 16'd10943) begin n_fail++; $display("FAIL alias_rd1 got %0d exp %0d", RD1, 10943); end
    n_checks++;
    if (RD2 !== 16'd10943) begin n_fail++; $display("FAIL alias_rd2 got %0d exp %0d", RD2, 10943); end
  endtask

  task automatic test_reset_dominance;
    @(negedge CLK);
    WEBAR = 1'b0; WA = 4'd5; WD = 16'd77; RSTBAR = 1'b0;
    RA1 = 4'd5; RA2 = 4'd8;
    @(posedge CLK);
    #1;
    n_checks++;
    if (RD1 !== 16'd0) begin n_fail++; $display("FAIL dom_r5_in_reset got %0d exp %0d", RD1, 0); end
    // Release mid-cycle with the write still requested.
    @(negedge CLK);
    RSTBAR = 1'b1;
    #1;
    n_checks++;
    if (RD1 !== 16'd0) begin n_fail++; $display("FAIL dom_r5_released got %0d exp %0d", RD1, 0); end
    n_checks++;
    if (RD2 !== 16'd0) begin n_fail++; $display("FAIL dom_r8_cleared got %0d exp %0d", RD2, 0); end
    @(posedge CLK);
    #1;
    n_checks++;
    if (RD1 !== 16'd77) begin n_fail++; $display("FAIL dom_first_write got %0d exp %0d", RD1, 77); end
    @(negedge CLK);
    WEBAR = 1'b1;
  endtask

  task automatic test_sweep;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    for (int i = 0; i < 16; i++) begin
      write_reg(4'(i), 16'(i * 3));
    end
    for (int i = 0; i < 16; i++) begin
      RA1 = 4'(i);
      RA2 = 4'(15 - i);
      exp_a = 16'(i * 3);
      exp_b = 16'((15 - i) * 3);
      #1;
      n_checks++;
      if (RD1 !== exp_a) begin n_fail++; $display("FAIL sweep_rd1 addr %0d got %0d exp %0d", i, RD1, exp_a); end
      n_checks++;
      if (RD2 !== exp_b) begin n_fail++; $display("FAIL sweep_rd2 addr %0d got %0d exp %0d", 15 - i, RD2, exp_b); end
    end
    n_checks++;
    if (DIS !== 16'd45) begin n_fail++; $display("FAIL sweep_dis got %0d exp %0d", DIS, 45); end
  endtask

  initial begin
    test_reset;
    test_reset_clear;
    test_basic_write;
    test_held_enable;
    test_write_disable;
    test_alias_same;
    test_reset_dominance;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
